nlc_horner_mc: RTL and testbench
================================

# nlc_horner_mc

Multi-channel, parametrised ADC non-linearity correction engine. It maps each raw ADC code through a per-channel, per-section centred-and-scaled polynomial and outputs the linearised code. Evaluation uses Horner's method on one shared signed fixed-point multiply-add datapath. The block sits between the ADC capture interface and the downstream filter chain, with valid/ready handshakes on both sides and a register-mapped coefficient table.

## Interface
Parameters:
- CHANNELS, 2: number of ADC channels; each channel has its own table.
- XW, 21: ADC code width, signed.
- NSEC, 4: sections per channel.
- ORDER, 7: polynomial order. Each section has ORDER+1 coefficients.
- CW, 36: coefficient and accumulator width, signed.
- FRAC, 12: fractional bits of coefficients, rscale and accumulator (format Q(FRAC)).

Ports:
- clk  in  1  clock
- reset  in  1  **reset, synchronous, active-high; clock clk.**
- in_valid  in  1  input sample valid
- in_ready  out  1  engine can accept a sample
- in_ch  in  max(1,clog2(CHANNELS))  channel tag
- in_data  in  XW  signed ADC code
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts the result
- out_ch  out  same as in_ch  echoed channel tag
- out_data  out  XW  signed linearised code
- cfg_we  in  1  table write strobe
- cfg_ch  in  same as in_ch  channel being written
- cfg_addr  in  8  word address within the channel table
- cfg_wdata  in  CW  write data

## Operation
- Table map, per channel, with S = ORDER+3:
  - Section s occupies words s·S … s·S+S−1.
  - Word s·S+k holds coefficient c[k], k = 0..ORDER.
  - Word s·S+ORDER+1 holds mean; it uses the low XW bits of cfg_wdata, signed.
  - Word s·S+ORDER+2 holds rscale (Q(FRAC)).
  - Section limits lim[i], i = 0..NSEC−2, are at words NSEC·S+i and use the low XW bits, signed.
  - Writes to out-of-range addresses, or with cfg_ch ≥ CHANNELS, are ignored.
- Table reset values (identity) for every channel and section:
  - c[1] = 1<<FRAC; all other coefficients 0.
  - mean = 0; rscale = 1<<FRAC; limits = 0.
- Section select: s = number of i with x ≥ lim[i]. Limits are programmed ascending.
- If in_ch ≥ CHANNELS, the sample uses channel 0's table and out_ch echoes in_ch.
- Arithmetic:
  - d = x − mean, computed at XW+1 bits.
  - u = satCW(d·rscale), in Q(FRAC).
  - acc starts at c[ORDER]. For k = ORDER−1 down to 0: acc = satCW(((acc·u) >>> FRAC) + c[k]), with a 2·CW-bit product and arithmetic shift (floor).
  - out_data = satXW(acc >>> FRAC), using floor.
  - sat clamps to the signed min/max of the given width.
- State machine:
  - IDLE: in_ready = !cfg_we. If in_valid && in_ready, capture in_data and in_ch, then go to SEL.
  - SEL: select section, compute d, acc = c[ORDER]; go to NORM.
  - NORM: compute u, k = ORDER−1; go to HORN.
  - HORN: perform one Horner step per cycle. When k = 0, register out_data and go to OUT; otherwise k−−.
  - OUT: out_valid = 1. On out_valid && out_ready, go to IDLE.
- Config writes apply on the clock edge in any state. When cfg_we is high in IDLE, the input is not accepted that cycle. Rewriting a channel's table while that channel's sample is in flight gives an unspecified result for that sample only.

## Timing
- Reset values: in_ready = 0 during the reset cycle and 1 in the first cycle after it; out_valid = 0, out_data = 0, out_ch = 0; state = IDLE; tables hold the identity values.
- Accept edge = edge 0. out_valid rises after edge ORDER+2 (edge 9 at the default ORDER).
- Sustained throughput with out_ready = 1: one sample per ORDER+4 cycles. in_ready is low from SEL through OUT.
- While out_ready = 0 in OUT, out_valid, out_data and out_ch hold stable.
- Reset asserted in any state aborts the sample. The next edge returns all outputs and tables to reset values, with no residual out_valid.
- cfg_we and an in_valid in IDLE in the same cycle: the write is performed and the sample waits.

## Test plan
- After reset, ch0 in_data = 1000 → out_data = 1000, out_ch = 0, out_valid 9 cycles after accept. Same check for −1048576 and 1048575.
- Program ch1 section 0 with c0 = 5<<12, c1 = 2<<12, other coefficients 0; keep mean 0, rscale 1.0; set lim = {100,200,300}. Expect:
  - ch1 x = 99 → 203.
  - ch1 x = 100 → 100 (section 1 is identity).
  - ch0 x = 99 → 99 (channel isolation).
- Program ch0 section 3 with c1 = 4<<12: x = 1000000 → 1048575 (saturated). Repeat with c1 = −4<<12 → −1048576.
- Hold out_ready = 0 for 5 cycles in OUT: out_valid stays 1, out_data stays stable, in_ready stays 0. Release: handshake, then in_ready = 1 on the next cycle.
- Assert reset during HORN: out_valid never rises, outputs are 0, and the identity table is restored (x = 7 → 7).
- Hold cfg_we high for 3 cycles with in_valid high in IDLE: in_ready stays 0 for those 3 cycles; the sample is accepted on the first cycle after cfg_we drops.

Source files
------------

// File: rtl/nlc_horner_mc.sv
// Multi-channel ADC non-linearity correction: per-channel, per-section polynomial evaluated by
// Horner's method on one shared signed Q(FRAC) multiply-add, with valid/ready on both sides.
module nlc_horner_mc #(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned XW       = 21,
    parameter int unsigned NSEC     = 4,
    parameter int unsigned ORDER    = 7,
    parameter int unsigned CW       = 36,
    parameter int unsigned FRAC     = 12,
    localparam int unsigned CHW     = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [CHW-1:0]       in_ch,
    input  logic [XW-1:0]        in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [CHW-1:0]       out_ch,
    output logic [XW-1:0]        out_data,
    input  logic                 cfg_we,
    input  logic [CHW-1:0]       cfg_ch,
    input  logic [7:0]           cfg_addr,
    input  logic [CW-1:0]        cfg_wdata
);

    localparam int unsigned S       = ORDER + 3;
    localparam int unsigned LIMBASE = NSEC * S;
    localparam int unsigned NLIM    = (NSEC > 1) ? NSEC - 1 : 1;
    localparam int unsigned SW      = (NSEC > 1) ? $clog2(NSEC) : 1;
    localparam int unsigned KW      = (ORDER > 1) ? $clog2(ORDER) : 1;
    localparam logic signed [CW-1:0] ONE = {{(CW-FRAC-1){1'b0}}, 1'b1, {FRAC{1'b0}}};

    typedef enum logic [2:0] {StIdle, StSel, StNorm, StHorn, StOut} state_e;

    logic signed [CW-1:0] coef_q   [CHANNELS][NSEC][ORDER+1];
    logic signed [CW-1:0] rscale_q [CHANNELS][NSEC];
    logic signed [XW-1:0] mean_q   [CHANNELS][NSEC];
    logic signed [XW-1:0] lim_q    [CHANNELS][NLIM];

    state_e               state_q;
    logic signed [XW-1:0] x_q;
    logic [CHW-1:0]       ch_q, tch_q;
    logic [SW-1:0]        sec_q;
    logic signed [XW:0]   d_q;
    logic signed [CW-1:0] acc_q, u_q;
    logic [KW-1:0]        k_q;
    logic                 out_valid_q;
    logic [XW-1:0]        out_data_q;
    logic [CHW-1:0]       out_ch_q;

    logic [31:0]            cfg_ch_w, cfg_addr_w, in_ch_w;
    logic [SW-1:0]          sec_sel;
    logic signed [XW:0]     d_sel;
    logic signed [2*CW-1:0] d_x, rs_x, nprod, acc_x, u_x, hprod, c_x;
    logic signed [CW-1:0]   horn;

    function automatic logic signed [CW-1:0] sat_cw(input logic signed [2*CW-1:0] v);
        if (&v[2*CW-1:CW-1] || ~|v[2*CW-1:CW-1]) return v[CW-1:0];
        else if (v[2*CW-1]) return {1'b1, {(CW-1){1'b0}}};
        else return {1'b0, {(CW-1){1'b1}}};
    endfunction

    function automatic logic signed [XW-1:0] sat_xw(input logic signed [CW-1:0] v);
        if (&v[CW-1:XW-1] || ~|v[CW-1:XW-1]) return v[XW-1:0];
        else if (v[CW-1]) return {1'b1, {(XW-1){1'b0}}};
        else return {1'b0, {(XW-1){1'b1}}};
    endfunction

    assign cfg_ch_w   = 32'(cfg_ch);
    assign cfg_addr_w = {24'd0, cfg_addr};
    assign in_ch_w    = 32'(in_ch);

    assign in_ready  = (state_q == StIdle) && !cfg_we && !reset;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_ch    = out_ch_q;

    // Coefficient table; reset restores the identity polynomial everywhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                for (int unsigned s = 0; s < NSEC; s++) begin
                    for (int unsigned k = 0; k <= ORDER; k++) begin
                        coef_q[c][s][k] <= (k == 1) ? ONE : '0;
                    end
                    mean_q[c][s]   <= '0;
                    rscale_q[c][s] <= ONE;
                end
                for (int unsigned i = 0; i < NLIM; i++) lim_q[c][i] <= '0;
            end
        end else if (cfg_we) begin
            for (int unsigned c = 0; c < CHANNELS; c++) begin
                if (cfg_ch_w == c) begin
                    for (int unsigned s = 0; s < NSEC; s++) begin
                        for (int unsigned k = 0; k <= ORDER; k++) begin
                            if (cfg_addr_w == s * S + k) coef_q[c][s][k] <= cfg_wdata;
                        end
                        if (cfg_addr_w == s * S + ORDER + 1) mean_q[c][s] <= cfg_wdata[XW-1:0];
                        if (cfg_addr_w == s * S + ORDER + 2) rscale_q[c][s] <= cfg_wdata;
                    end
                    for (int unsigned i = 0; i < NSEC - 1; i++) begin
                        if (cfg_addr_w == LIMBASE + i) lim_q[c][i] <= cfg_wdata[XW-1:0];
                    end
                end
            end
        end
    end

    always_comb begin
        int unsigned cnt;
        cnt = 0;
        for (int unsigned i = 0; i < NSEC - 1; i++) begin
            if (x_q >= lim_q[tch_q][i]) cnt++;
        end
        sec_sel = SW'(cnt);
        d_sel   = {x_q[XW-1], x_q} - {mean_q[tch_q][sec_sel][XW-1], mean_q[tch_q][sec_sel]};
    end

    // Shared datapath: d*rscale in NORM, acc*u + c[k] in HORN, all at 2*CW bits.
    always_comb begin
        d_x   = {{(2*CW-XW-1){d_q[XW]}}, d_q};
        rs_x  = {{CW{rscale_q[tch_q][sec_q][CW-1]}}, rscale_q[tch_q][sec_q]};
        nprod = d_x * rs_x;
        acc_x = {{CW{acc_q[CW-1]}}, acc_q};
        u_x   = {{CW{u_q[CW-1]}}, u_q};
        hprod = acc_x * u_x;
        c_x   = {{CW{coef_q[tch_q][sec_q][k_q][CW-1]}}, coef_q[tch_q][sec_q][k_q]};
        horn  = sat_cw((hprod >>> FRAC) + c_x);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            x_q         <= '0;
            ch_q        <= '0;
            tch_q       <= '0;
            sec_q       <= '0;
            d_q         <= '0;
            acc_q       <= '0;
            u_q         <= '0;
            k_q         <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_ch_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid && in_ready) begin
                        x_q     <= in_data;
                        ch_q    <= in_ch;
                        tch_q   <= (in_ch_w < CHANNELS) ? in_ch : '0;
                        state_q <= StSel;
                    end
                end
                StSel: begin
                    sec_q   <= sec_sel;
                    d_q     <= d_sel;
                    acc_q   <= coef_q[tch_q][sec_sel][ORDER];
                    state_q <= StNorm;
                end
                StNorm: begin
                    u_q     <= sat_cw(nprod);
                    k_q     <= KW'(ORDER - 1);
                    state_q <= StHorn;
                end
                StHorn: begin
                    acc_q <= horn;
                    if (k_q == '0) begin
                        out_data_q  <= sat_xw(horn >>> FRAC);
                        out_ch_q    <= ch_q;
                        out_valid_q <= 1'b1;
                        state_q     <= StOut;
                    end else begin
                        k_q <= k_q - 1'b1;
                    end
                end
                StOut: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_nlc_horner_mc.sv
// Directed bench for nlc_horner_mc: expected results queued at send time, checked at output.
module tb_nlc_horner_mc;

    localparam int ORDER = 7;
    localparam int XW    = 21;
    localparam int CW    = 36;
    localparam int LAT   = ORDER + 2;

    logic                 clk = 1'b0;
    logic                 reset = 1'b1;
    logic                 in_valid = 1'b0;
    logic                 in_ready;
    logic [0:0]           in_ch = '0;
    logic signed [XW-1:0] in_data = '0;
    logic                 out_valid;
    logic                 out_ready = 1'b1;
    logic [0:0]           out_ch;
    logic signed [XW-1:0] out_data;
    logic                 cfg_we = 1'b0;
    logic [0:0]           cfg_ch = '0;
    logic [7:0]           cfg_addr = '0;
    logic [CW-1:0]        cfg_wdata = '0;

    typedef struct {
        logic [0:0]           ch;
        logic signed [XW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    nlc_horner_mc dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_ch     (in_ch),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_ch    (out_ch),
        .out_data  (out_data),
        .cfg_we    (cfg_we),
        .cfg_ch    (cfg_ch),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic cfg_write(input logic [0:0] ch, input int addr, input logic [CW-1:0] data);
        cfg_we    = 1'b1;
        cfg_ch    = ch;
        cfg_addr  = 8'(addr);
        cfg_wdata = data;
        step();
        cfg_we    = 1'b0;
    endtask

    // Drive one sample, optionally recording its expected result.
    task automatic send(input logic [0:0] ch, input int x, input bit push, input int exp);
        exp_t e;
        int   n;
        if (push) begin
            e.ch   = ch;
            e.data = XW'(exp);
            sb.push_back(e);
        end
        in_ch    = ch;
        in_data  = XW'(x);
        in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 40) begin
            step();
            n++;
        end
        chk("in_ready_seen", 64'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk("in_ready_busy", 64'(in_ready), 0);
    endtask

    // Wait for out_valid after an accept, check latency and the scoreboard head.
    task automatic receive();
        exp_t e;
        int   lat;
        lat = 0;
        while (!out_valid && lat < 40) begin
            step();
            lat++;
        end
        chk("latency", 64'(lat), 64'(LAT));
        if (sb.size() == 0) begin
            chk("sb_nonempty", 64'(sb.size()), 1);
        end else begin
            e = sb.pop_front();
            chk("out_data", 64'(out_data), 64'(e.data));
            chk("out_ch", 64'(out_ch), 64'(e.ch));
        end
        if (out_ready) begin
            step();
            chk("out_valid_drop", 64'(out_valid), 0);
        end
    endtask

    task automatic run(input logic [0:0] ch, input int x, input int exp);
        send(ch, x, 1'b1, exp);
        receive();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit seen;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(in_ready), 0);
        chk("rst_out_valid", 64'(out_valid), 0);
        chk("rst_out_data", 64'(out_data), 0);
        chk("rst_out_ch", 64'(out_ch), 0);
        reset = 1'b0;
        #1;
        chk("post_rst_in_ready", 64'(in_ready), 1);

        // Identity table
        run(1'b0, 1000, 1000);
        run(1'b0, -1048576, -1048576);
        run(1'b0, 1048575, 1048575);

        // ch1 section 0: 5 + 2x; limits 100/200/300
        cfg_write(1'b1, 0, 36'(5 << 12));
        cfg_write(1'b1, 1, 36'(2 << 12));
        cfg_write(1'b1, 40, 36'(100));
        cfg_write(1'b1, 41, 36'(200));
        cfg_write(1'b1, 42, 36'(300));
        run(1'b1, 99, 203);
        run(1'b1, 100, 100);
        run(1'b0, 99, 99);

        // ch0 section 3 gain of +/-4 saturates
        cfg_write(1'b0, 31, 36'(4 << 12));
        run(1'b0, 1000000, 1048575);
        cfg_write(1'b0, 31, -36'sd16384);
        run(1'b0, 1000000, -1048576);

        // Backpressure: output held while out_ready is low
        out_ready = 1'b0;
        send(1'b0, 5, 1'b1, -20);
        receive();
        for (int i = 0; i < 5; i++) begin
            step();
            chk("hold_valid", 64'(out_valid), 1);
            chk("hold_data", 64'(out_data), -20);
            chk("hold_in_ready", 64'(in_ready), 0);
        end
        out_ready = 1'b1;
        step();
        chk("release_valid", 64'(out_valid), 0);
        chk("release_in_ready", 64'(in_ready), 1);

        // Reset in the middle of HORN aborts the sample
        send(1'b0, 7, 1'b0, 0);
        repeat (4) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("abort_out_valid", 64'(out_valid), 0);
        chk("abort_out_data", 64'(out_data), 0);
        chk("abort_out_ch", 64'(out_ch), 0);
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid) seen = 1'b1;
        end
        chk("abort_no_valid", 64'(seen), 0);
        run(1'b0, 7, 7);
        run(1'b1, 99, 99);

        // cfg_we blocks acceptance; sample taken after it drops
        sb.push_back('{ch: 1'b0, data: XW'(11)});
        in_ch    = 1'b0;
        in_data  = XW'(11);
        in_valid = 1'b1;
        cfg_we   = 1'b1;
        cfg_ch   = 1'b1;
        cfg_addr = 8'd200;
        cfg_wdata = 36'(12345);
        #1;
        chk("cfg_block_0", 64'(in_ready), 0);
        step();
        chk("cfg_block_1", 64'(in_ready), 0);
        step();
        chk("cfg_block_2", 64'(in_ready), 0);
        step();
        cfg_we = 1'b0;
        #1;
        chk("cfg_release", 64'(in_ready), 1);
        step();
        in_valid = 1'b0;
        chk("cfg_accepted", 64'(in_ready), 0);
        receive();
        run(1'b1, 50, 50);

        chk("sb_drained", 64'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
